// File: rtl/word_deserializer_pkg.sv
// rtl/word_deserializer_pkg.sv - shared constants and sizing helper for the word deserializer
package word_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_SIZE  = 3;

  // Never returns 0 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << bits) < value) bits = bits + 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/word_deserializer_if.sv
// rtl/word_deserializer_if.sv - word input and frame output handshake bundle
interface word_deserializer_if #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3
);

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH*SIZE-1:0]   dout;

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dout
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dout
  );

endinterface

// File: rtl/word_deserializer.sv
// rtl/word_deserializer.sv - collects SIZE serial words into one frame behind a valid/ready holding register
module word_deserializer
  import word_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SIZE  = DEFAULT_SIZE
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ce,
  input  logic               i_clear,
  input  logic               i_dir,
  output logic               o_busy,
  word_deserializer_if.slave bus
);

  localparam int FW = WIDTH * SIZE;
  localparam int CW = clog2(SIZE);

  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_sr;
  logic          r_frame_dir;
  logic [FW-1:0] r_dout;
  logic          r_out_valid;

  logic          w_last;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_dir;
  logic [FW-1:0] w_shifted;

  assign w_last = (r_cnt == CW'(SIZE - 1));

  // Only the closing word needs a free holding register; earlier words assemble in r_sr.
  assign w_in_ready = i_rst_n && i_ce && !i_clear &&
                      !(w_last && r_out_valid && !bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_dir     = (r_cnt == '0) ? i_dir : r_frame_dir;
  assign w_shifted = w_dir ? {bus.data_in, r_sr[FW-1:WIDTH]}
                           : {r_sr[FW-WIDTH-1:0], bus.data_in};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_sr        <= '0;
      r_frame_dir <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (w_accept) begin
      if (r_cnt == '0) r_frame_dir <= i_dir;
      if (w_last) begin
        r_cnt <= '0;
        r_sr  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_sr  <= w_shifted;
      end
    end
  end

  // A completion on the same edge as a drain refills the register with no bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept && w_last) begin
      r_dout      <= w_shifted;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign o_busy        = (r_cnt != '0);

endmodule

// File: tb/tb_word_deserializer.sv
// tb/tb_word_deserializer.sv - directed self-checking bench for word_deserializer
module tb_word_deserializer;

  logic clk;
  logic rst_n;
  logic ce;
  logic clear;
  logic dir;
  logic busy;
  int   checks;
  int   errors;

  word_deserializer_if #(.WIDTH(4), .SIZE(3)) bus ();

  word_deserializer #(.WIDTH(4), .SIZE(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_ce    (ce),
    .i_clear (clear),
    .i_dir   (dir),
    .o_busy  (busy),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] w);
    bus.in_valid = 1'b1;
    bus.data_in  = w;
    tick();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    ce            = 1'b1;
    clear         = 1'b0;
    dir           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = 4'h0;
    bus.out_ready = 1'b1;

    #12;
    chk1 ("rst_out_valid", bus.out_valid, 1'b0);
    chk12("rst_dout",      bus.dout,      12'h000);
    chk1 ("rst_busy",      busy,          1'b0);
    chk1 ("rst_in_ready",  bus.in_ready,  1'b0);
    rst_n = 1'b1;
    #1;
    chk1 ("post_rst_in_ready", bus.in_ready, 1'b1);
    tick();

    // dir=0 basic frame
    put(4'ha);
    chk1 ("basic_busy_a", busy, 1'b1);
    put(4'hb);
    put(4'hc);
    chk1 ("basic_valid", bus.out_valid, 1'b1);
    chk12("basic_dout",  bus.dout,      12'habc);
    chk1 ("basic_busy_done", busy, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk1 ("basic_drained", bus.out_valid, 1'b0);
    chk12("basic_dout_kept", bus.dout, 12'habc);

    // dir=1, toggled back to 0 mid-frame
    dir = 1'b1;
    put(4'hd);
    dir = 1'b0;
    put(4'he);
    put(4'hf);
    chk1 ("dir_valid", bus.out_valid, 1'b1);
    chk12("dir_dout",  bus.dout,      12'hfed);
    bus.in_valid = 1'b0;
    tick();

    // backpressure with frame abc pending
    bus.out_ready = 1'b0;
    put(4'ha);
    put(4'hb);
    put(4'hc);
    chk12("bp_first_dout", bus.dout, 12'habc);
    put(4'h1);
    put(4'h2);
    bus.data_in = 4'h3;
    #1;
    chk1 ("bp_in_ready_low", bus.in_ready, 1'b0);
    tick();
    chk12("bp_dout_held",  bus.dout,      12'habc);
    chk1 ("bp_valid_held", bus.out_valid, 1'b1);
    chk1 ("bp_busy",       busy,          1'b1);
    bus.out_ready = 1'b1;
    #1;
    chk1 ("bp_in_ready_high", bus.in_ready, 1'b1);
    tick();
    chk12("bp_new_dout",  bus.dout,      12'h123);
    chk1 ("bp_no_bubble", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    chk1 ("bp_drained", bus.out_valid, 1'b0);

    // clear aborts partial frame
    put(4'ha);
    put(4'hb);
    clear       = 1'b1;
    bus.in_valid = 1'b1;
    bus.data_in = 4'hc;
    #1;
    chk1 ("clr_in_ready", bus.in_ready, 1'b0);
    tick();
    chk1 ("clr_busy",  busy,          1'b0);
    chk1 ("clr_valid", bus.out_valid, 1'b0);
    clear = 1'b0;
    put(4'h4);
    put(4'h5);
    put(4'h6);
    chk12("clr_dout",  bus.dout,      12'h456);
    chk1 ("clr_valid2", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    tick();

    // ce=0 mid-frame
    put(4'ha);
    put(4'hb);
    ce          = 1'b0;
    bus.data_in = 4'hc;
    #1;
    chk1 ("ce_in_ready", bus.in_ready, 1'b0);
    repeat (5) tick();
    chk1 ("ce_busy_hold", busy,          1'b1);
    chk1 ("ce_no_frame",  bus.out_valid, 1'b0);
    ce = 1'b1;
    tick();
    chk12("ce_dout",  bus.dout,      12'habc);
    chk1 ("ce_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    tick();

    // asynchronous reset mid-frame
    put(4'h7);
    put(4'h8);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk1 ("arst_busy",     busy,          1'b0);
    chk1 ("arst_in_ready", bus.in_ready,  1'b0);
    chk1 ("arst_valid",    bus.out_valid, 1'b0);
    chk12("arst_dout",     bus.dout,      12'h000);
    #1;
    rst_n = 1'b1;
    tick();
    put(4'h9);
    put(4'he);
    put(4'h5);
    chk12("arst_new_dout", bus.dout,      12'h9e5);
    chk1 ("arst_new_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
